// File: rtl/pipe_reg32_skid_pkg.sv
// Shared constants for the pipe_reg32_skid stage: default widths and FSM state encodings.
package pipe_reg32_skid_pkg;

    localparam int DEF_WIDTH   = 32;
    localparam int DEF_COUNT_W = 16;

    // 2'b11 is unused; the FSM treats it as illegal and returns to EMPTY.
    localparam logic [1:0] ST_EMPTY = 2'b00;
    localparam logic [1:0] ST_BUSY  = 2'b01;
    localparam logic [1:0] ST_FULL  = 2'b10;

endpackage

// File: rtl/pipe_reg32_skid_reg_en_w.sv
// Width-parameterised register with asynchronous active-high clear and load enable.
module reg_en_w #(
    parameter int WIDTH = 33
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_reg <= '0;
        end else if (en) begin
            q_reg <= d;
        end
    end

    assign q = q_reg;

endmodule

// File: rtl/pipe_reg32_skid.sv
// Valid/ready pipeline stage with one skid entry behind the 32-bit operand mux.
// Carries the mux select as a tag and counts delivered words.
module pipe_reg32_skid
    import pipe_reg32_skid_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int COUNT_W = DEF_COUNT_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic               in_sel,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_sel,
    output logic [COUNT_W-1:0] xfer_count
);

    logic [1:0]         state_reg;
    logic [1:0]         state_next;
    logic               accept;
    logic               deliver;
    logic               load_main;
    logic               load_skid;
    logic               main_from_skid;
    logic [WIDTH:0]     in_word;
    logic [WIDTH:0]     main_d;
    logic [WIDTH:0]     main_q;
    logic [WIDTH:0]     skid_q;
    logic [COUNT_W-1:0] xfer_count_reg;

    // Handshake decode depends only on the state register, so out_ready never reaches in_ready.
    assign out_valid = (state_reg != ST_EMPTY);
    assign in_ready  = (state_reg != ST_FULL);
    assign accept    = in_valid & in_ready;
    assign deliver   = out_valid & out_ready;

    assign in_word = {in_sel, in_data};
    assign main_d  = main_from_skid ? skid_q : in_word;

    always_comb begin
        state_next     = state_reg;
        load_main      = 1'b0;
        load_skid      = 1'b0;
        main_from_skid = 1'b0;
        case (state_reg)
            ST_EMPTY: begin
                if (accept) begin
                    load_main  = 1'b1;
                    state_next = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (accept && deliver) begin
                    load_main = 1'b1;
                end else if (accept) begin
                    load_skid  = 1'b1;
                    state_next = ST_FULL;
                end else if (deliver) begin
                    state_next = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (deliver) begin
                    load_main      = 1'b1;
                    main_from_skid = 1'b1;
                    state_next     = ST_BUSY;
                end
            end
            default: state_next = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= ST_EMPTY;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            xfer_count_reg <= '0;
        end else if (deliver) begin
            xfer_count_reg <= xfer_count_reg + COUNT_W'(1);
        end
    end

    reg_en_w #(.WIDTH(WIDTH + 1)) u_main (
        .clk   (clk),
        .reset (reset),
        .en    (load_main),
        .d     (main_d),
        .q     (main_q)
    );

    reg_en_w #(.WIDTH(WIDTH + 1)) u_skid (
        .clk   (clk),
        .reset (reset),
        .en    (load_skid),
        .d     (in_word),
        .q     (skid_q)
    );

    assign out_sel    = main_q[WIDTH];
    assign out_data   = main_q[WIDTH-1:0];
    assign xfer_count = xfer_count_reg;

endmodule

// File: tb/tb_pipe_reg32_skid.sv
// Directed bench for pipe_reg32_skid: reset, single word, streaming, skid stall,
// reset while FULL, and counter wrap on a 4-bit-counter instance.
module tb_pipe_reg32_skid;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_sel;
    logic        out_ready;

    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_sel;
    logic [15:0] xfer_count;

    logic        in_ready4;
    logic        out_valid4;
    logic [31:0] out_data4;
    logic        out_sel4;
    logic [3:0]  xfer_count4;

    int errors = 0;
    int checks = 0;

    pipe_reg32_skid u_dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_sel    (out_sel),
        .xfer_count (xfer_count)
    );

    pipe_reg32_skid #(.WIDTH(32), .COUNT_W(4)) u_dut4 (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready4),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .out_valid  (out_valid4),
        .out_ready  (out_ready),
        .out_data   (out_data4),
        .out_sel    (out_sel4),
        .xfer_count (xfer_count4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end else begin
            $display("ok   %s: %0h", tag, obs);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_sel    = 1'b0;
        out_ready = 1'b0;

        // Reset applied before any clock edge must take effect immediately.
        #3;
        reset = 1'b1;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_data", out_data, 0);
        check("rst_out_sel", out_sel, 0);
        check("rst_xfer", xfer_count, 0);
        tick;
        tick;
        reset = 1'b0;

        // Single word
        in_valid  = 1'b1;
        in_data   = 32'hAAAAAAAA;
        in_sel    = 1'b0;
        out_ready = 1'b1;
        tick;
        in_valid = 1'b0;
        check("single_valid", out_valid, 1);
        check("single_data", out_data, 32'hAAAAAAAA);
        check("single_sel", out_sel, 0);
        tick;
        check("single_drop", out_valid, 0);
        check("single_xfer", xfer_count, 1);

        // Streaming 8 words, alternating sel
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_data  = i;
            in_sel   = i[0];
            check("stream_in_ready", in_ready, 1);
            tick;
            check("stream_valid", out_valid, 1);
            check("stream_data", out_data, i);
            check("stream_sel", out_sel, i[0]);
        end
        in_valid = 1'b0;
        tick;
        check("stream_drop", out_valid, 0);
        check("stream_xfer", xfer_count, 9);

        // Stall into the skid entry
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h55555555;
        in_sel    = 1'b1;
        tick;
        in_data = 32'h12345678;
        in_sel  = 1'b0;
        tick;
        // Junk offered while FULL must be ignored.
        in_data = 32'hFFFFFFFF;
        in_sel  = 1'b1;
        check("full_in_ready", in_ready, 0);
        check("full_out_data", out_data, 32'h55555555);
        check("full_out_sel", out_sel, 1);
        tick;
        in_valid = 1'b0;
        check("stall_hold_data", out_data, 32'h55555555);
        check("stall_hold_valid", out_valid, 1);
        out_ready = 1'b1;
        tick;
        check("skid_data", out_data, 32'h12345678);
        check("skid_sel", out_sel, 0);
        check("skid_in_ready", in_ready, 1);
        tick;
        check("skid_drop", out_valid, 0);
        check("skid_xfer", xfer_count, 11);

        // Reset while FULL discards both words
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h0000AAA1;
        tick;
        in_data = 32'h0000AAA2;
        tick;
        in_valid = 1'b0;
        check("pre_rst_in_ready", in_ready, 0);
        reset = 1'b1;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_in_ready", in_ready, 1);
        check("midrst_out_data", out_data, 0);
        check("midrst_xfer", xfer_count, 0);
        tick;
        reset = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'hDEADBEEF;
        in_sel    = 1'b0;
        out_ready = 1'b1;
        tick;
        in_valid = 1'b0;
        check("post_rst_data", out_data, 32'hDEADBEEF);
        check("post_rst_valid", out_valid, 1);
        tick;
        check("post_rst_drop", out_valid, 0);
        check("post_rst_xfer", xfer_count, 1);

        // Counter wrap on the 4-bit instance: after edge j, j-1 deliveries have happened.
        reset = 1'b1;
        #1;
        reset = 1'b0;
        out_ready = 1'b1;
        for (int j = 1; j <= 17; j++) begin
            in_valid = 1'b1;
            in_data  = 32'h100 + j;
            tick;
            check("wrap_cnt4", xfer_count4, (j - 1) % 16);
        end
        in_valid = 1'b0;
        tick;
        check("wrap_final4", xfer_count4, 1);
        check("wrap_final16", xfer_count, 17);
        check("wrap_drop", out_valid4, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
